// File: rtl/video_pkg.sv
// Shared timing types and the 640x480@60 timing set for the video raster path.
package video_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    localparam timing_t VGA_640_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam timing_t VGA_480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};
    localparam int unsigned VGA_CW = 12;

    function automatic int unsigned total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/video_counter.sv
// Wrap counter 0..MAX-1 with enable and sync reset; carry flags the terminal count combinationally.
module video_counter #(
    parameter int unsigned CW  = 12,
    parameter int unsigned MAX = 800
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          carry
);

    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    assign carry = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= carry ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters decoded into registered sync, DE, X/Y and frame/line pulses.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640_H.active,
    parameter int unsigned H_FP     = VGA_640_H.fp,
    parameter int unsigned H_SYNC   = VGA_640_H.sync,
    parameter int unsigned H_BP     = VGA_640_H.bp,
    parameter int unsigned V_ACTIVE = VGA_480_V.active,
    parameter int unsigned V_FP     = VGA_480_V.fp,
    parameter int unsigned V_SYNC   = VGA_480_V.sync,
    parameter int unsigned V_BP     = VGA_480_V.bp,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CW       = VGA_CW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          DE,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          SOF,
    output logic          EOL
);

    localparam timing_t     H_T     = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t     V_T     = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int unsigned H_TOTAL = total(H_T);
    localparam int unsigned V_TOTAL = total(V_T);

    generate
        if (longint'(H_TOTAL) > (64'd1 << CW) || longint'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_width
            $error("video_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
        end
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CW == 0) begin : g_bad_zero
            $error("video_timing_gen: timing parameters must be non-zero");
        end
    endgenerate

    // Nonzero back porch keeps every boundary below 2^CW, so these casts cannot wrap.
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_carry;
    logic          v_carry;

    video_counter #(.CW(CW), .MAX(H_TOTAL)) u_h_counter (
        .clk   (CLK),
        .rst   (RST),
        .en    (CE),
        .cnt   (h_cnt),
        .carry (h_carry)
    );

    video_counter #(.CW(CW), .MAX(V_TOTAL)) u_v_counter (
        .clk   (CLK),
        .rst   (RST),
        .en    (CE & h_carry),
        .cnt   (v_cnt),
        .carry (v_carry)
    );

    logic de_d;
    logic hs_on;
    logic vs_on;
    logic sof_d;
    logic eol_d;

    always_comb begin
        de_d  = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_on = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_on = (v_cnt >= VS_START) && (v_cnt < VS_END);
        sof_d = (h_cnt == '0) && (v_cnt == '0);
        eol_d = (h_cnt == H_LAST_C) && (v_cnt < V_ACT_C);
    end

    // Pulses are cleared on idle CE cycles so they stay one CLK wide under a slow pixel enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            HSYNC <= ~H_POL;
            VSYNC <= ~V_POL;
            DE    <= 1'b0;
            X     <= '0;
            Y     <= '0;
            SOF   <= 1'b0;
            EOL   <= 1'b0;
        end else if (CE) begin
            HSYNC <= hs_on ? H_POL : ~H_POL;
            VSYNC <= vs_on ? V_POL : ~V_POL;
            DE    <= de_d;
            X     <= de_d ? h_cnt : '0;
            Y     <= de_d ? v_cnt : '0;
            SOF   <= sof_d;
            EOL   <= eol_d;
        end else begin
            SOF   <= 1'b0;
            EOL   <= 1'b0;
        end
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Generates raster timing for the HDMI/DVI path. Runs on the 25 MHz pixel clock produced by the PLL. Produces the sync, data-enable and pixel-coordinate signals consumed by the downstream pattern generator and TMDS encoders. Defaults give 640x480@60 (800x525 total).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, HSYNC asserted level (0 = active-low)
V_POL, 0, VSYNC asserted level (0 = active-low)
CW, 12, width of counters and X/Y outputs

Ports:
CLK  in  1  pixel clock (clk_25 from PLL)
RST  in  1  synchronous reset, active-high
CE   in  1  pixel enable; counters advance only when high
HSYNC  out  1  horizontal sync, polarity per H_POL
VSYNC  out  1  vertical sync, polarity per V_POL
DE  out  1  data enable, high during active area
X  out  CW  active pixel column, 0..H_ACTIVE-1
Y  out  CW  active line, 0..V_ACTIVE-1
SOF  out  1  one-cycle pulse on first active pixel of frame
EOL  out  1  one-cycle pulse on last active pixel of each active line

Behaviour:
- One clock domain, CLK. RST is synchronous and active-high. All outputs registered.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Elaboration error if H_TOTAL or V_TOTAL exceeds 2^CW, or if any parameter is 0.
- h_cnt counts 0..H_TOTAL-1 on CE and wraps to 0.
- v_cnt increments when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
- Outputs are decoded from the counter values and registered when CE=1. Latency is 1 CLK from counter state to outputs.
- DE = (h < H_ACTIVE) and (v < V_ACTIVE).
- X = h and Y = v when DE is high; both are 0 otherwise.
- HSYNC is asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- VSYNC is asserted when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines. VSYNC changes together with h = 0.
- SOF = 1 when h = 0 and v = 0. EOL = 1 when h = H_ACTIVE-1 and v < V_ACTIVE.
- Reset values: h_cnt = 0, v_cnt = 0, DE = 0, X = 0, Y = 0, SOF = 0, EOL = 0. HSYNC = ~H_POL and VSYNC = ~V_POL (deasserted).
- CE = 0: counters and the levels of HSYNC, VSYNC, DE, X and Y hold. SOF and EOL are forced to 0, so each pulse is one CLK wide even with a slow CE.
- First CE cycle after reset: the next edge gives DE = 1, X = 0, Y = 0, SOF = 1.
- RST mid-frame overrides CE and restarts at (0,0) with no partial-frame flush.
- Simultaneous h and v wrap (h = H_TOTAL-1, v = V_TOTAL-1): both counters return to 0 on the same edge.

Decomposition:
- Package video_pkg holds:
  - localparams for the 640x480@60 timing set;
  - typedef struct timing_t (active, fp, sync, bp);
  - helper function total(timing_t).
- One sub-module, video_counter: a parameterised wrap counter with enable, sync reset and a registered-free carry-out at the terminal count. Instantiated twice: horizontal, and vertical with its enable = CE & h_carry.

Test Plan:
- RST held 5 cycles, CE = 1 -> HSYNC = 1, VSYNC = 1, DE = 0, X = Y = 0, SOF = 0 throughout.
- Release RST, CE = 1 -> one cycle later SOF = 1, DE = 1, X = 0, Y = 0. SOF pulses again exactly 420000 CLK later.
- Line 0 -> DE high for 640 consecutive cycles, EOL coincides with X = 639. HSYNC low for 96 cycles starting 16 cycles after DE falls. Line period is 800 cycles.
- Full frame -> DE-high lines = 480. VSYNC low for exactly 1600 cycles, starting at the h = 0 of line 490. Y = 479 on the last EOL.
- CE alternating 1/0 -> SOF spacing 840000 CLK, SOF and EOL each 1 CLK wide. X increments every second CLK.
- RST pulsed for 1 cycle while Y = 200, X = 300 -> the next CE edge after release shows SOF = 1, X = 0, Y = 0. The following frame timing matches the reset-start case.
